// File: rtl/det_log_pkg.sv
// Shared definitions for the detection event logger: parameter defaults,
// the FIFO level-width helper and the per-cycle FIFO operation encoding.
// Latency: n/a. Backpressure: n/a.
package det_log_pkg;

  localparam int CNT_W_DEF      = 8;
  localparam int DEPTH_DEF      = 4;
  localparam int IRQ_THRESH_DEF = 2;

  // The level must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // What happens to the timestamp FIFO in a given cycle.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_PUSH_POP,
    OP_DROP
  } fifo_op_e;

endpackage

// File: rtl/det_event_logger_if.sv
// Read port of the event logger: head timestamp offered with valid/ready.
// Latency: n/a (wires only).
// Backpressure: rd_data is held while rd_valid && !rd_ready.
//   master: drives rd_valid, rd_data; samples rd_ready (the logger side)
//   slave : samples rd_valid, rd_data; drives rd_ready (the host side)
interface det_event_logger_if
  import det_log_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             rd_valid;
  logic             rd_ready;
  logic [CNT_W-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/det_log_fifo.sv
// Synchronous FIFO for event timestamps with flush.
// Latency: a push is visible at the head one cycle later. Backpressure: a push
// is accepted when not full or when a pop frees a slot in the same cycle.
//   ports: clk, rstn, flush, push/push_data, pop, vld, head, level, level_nxt, full
module det_log_fifo
  import det_log_pkg::*;
#(
  parameter  int W     = CNT_W_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = lvl_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          vld,
  output logic [W-1:0]  head,
  output logic [LW-1:0] level,
  output logic [LW-1:0] level_nxt,
  output logic          full
);

  logic [W-1:0] mem [DEPTH];
  // Pointers carry one wrap bit so that full and empty are distinguishable.
  logic [AW:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic         do_push, do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign vld     = (level != '0);
  assign full    = (level == LW'(DEPTH));
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && vld;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_nxt = wr_ptr;
    rd_nxt = rd_ptr;
    if (flush) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end else begin
      if (do_push) wr_nxt = wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_nxt = rd_ptr + (AW+1)'(1);
    end
  end

  assign level_nxt = wr_nxt - rd_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      // Flushing the storage too keeps the head at zero after a clear.
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
      end
    end
  end

endmodule

// File: rtl/det_event_logger.sv
// Turns rising edges of the detector output into timestamped FIFO events.
// Latency: event stamp visible on the read port one cycle after the edge.
// Backpressure: full FIFO without a pop drops the event and sets overflow.
//   ports: clk, rstn, bit_en, detected, clear, rd (valid/ready read port),
//          event_cnt, fifo_level, overflow, irq
module det_event_logger
  import det_log_pkg::*;
#(
  parameter  int CNT_W      = CNT_W_DEF,
  parameter  int DEPTH      = DEPTH_DEF,
  parameter  int IRQ_THRESH = IRQ_THRESH_DEF,
  localparam int LW         = lvl_w(DEPTH)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                bit_en,
  input  logic                detected,
  input  logic                clear,
  det_event_logger_if.master  rd,
  output logic [CNT_W-1:0]    event_cnt,
  output logic [LW-1:0]       fifo_level,
  output logic                overflow,
  output logic                irq
);

  localparam logic [LW-1:0]    IRQ_LVL = LW'(IRQ_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] bit_cnt;
  logic             det_q;
  logic             evt;
  logic             pop_ok;
  fifo_op_e         op;
  logic             fifo_vld;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_head;
  logic [LW-1:0]    lvl_nxt;

  assign evt    = detected && !det_q;
  assign pop_ok = rd.rd_ready && fifo_vld;

  // A pop in the same cycle makes room, so a full FIFO only drops when idle.
  // clear overrides everything that would touch the FIFO this cycle.
  always_comb begin
    op = OP_IDLE;
    if (!clear) begin
      if (evt && (!fifo_full || pop_ok)) op = pop_ok ? OP_PUSH_POP : OP_PUSH;
      else if (evt)                      op = OP_DROP;
      else if (pop_ok)                   op = OP_POP;
    end
  end

  det_log_fifo #(
    .W     (CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (clear),
    .push      ((op == OP_PUSH) || (op == OP_PUSH_POP)),
    .push_data (bit_cnt),
    .pop       ((op == OP_POP) || (op == OP_PUSH_POP)),
    .vld       (fifo_vld),
    .head      (fifo_head),
    .level     (fifo_level),
    .level_nxt (lvl_nxt),
    .full      (fifo_full)
  );

  assign rd.rd_valid = fifo_vld;
  assign rd.rd_data  = fifo_head;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt   <= '0;
      det_q     <= 1'b0;
      event_cnt <= '0;
      overflow  <= 1'b0;
      irq       <= 1'b0;
    end else begin
      // Edge history keeps tracking through clear so a held level is not
      // re-counted as a fresh event afterwards.
      det_q <= detected;
      if (clear) begin
        bit_cnt   <= '0;
        event_cnt <= '0;
        overflow  <= 1'b0;
        irq       <= 1'b0;
      end else begin
        if (bit_en) bit_cnt <= bit_cnt + CNT_W'(1);
        if (evt && (event_cnt != CNT_MAX)) event_cnt <= event_cnt + CNT_W'(1);
        if (op == OP_DROP) overflow <= 1'b1;
        // Compare against the next level so irq moves with fifo_level.
        irq <= (lvl_nxt >= IRQ_LVL);
      end
    end
  end

endmodule

// File: tb/tb_det_event_logger.sv
module tb_det_event_logger;
  import det_log_pkg::*;

  localparam int CW = 8;
  localparam int DP = 4;
  localparam int TH = 2;
  localparam int LW = lvl_w(DP);

  logic          clk = 1'b0;
  logic          rstn;
  logic          bit_en, detected, clear;
  logic [CW-1:0] event_cnt;
  logic [LW-1:0] fifo_level;
  logic          overflow, irq;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  det_event_logger_if #(.CNT_W(CW)) rd_if ();

  det_event_logger #(.CNT_W(CW), .DEPTH(DP), .IRQ_THRESH(TH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bit_en     (bit_en),
    .detected   (detected),
    .clear      (clear),
    .rd         (rd_if),
    .event_cnt  (event_cnt),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .irq        (irq)
  );

  // Reference model: a queue of stamps plus plain counters.
  logic [CW-1:0] m_q[$];
  int            m_bit, m_evt;
  logic          m_ovf, m_detp;

  task automatic model_reset();
    m_q.delete();
    m_bit = 0; m_evt = 0; m_ovf = 1'b0; m_detp = 1'b0;
  endtask

  // Drive one cycle of inputs, step the model on the edge, settle #1 after it.
  task automatic cycle(input logic en, input logic det, input logic clr, input logic rdy);
    logic     ev, popd;
    fifo_op_e op;
    logic [CW-1:0] junk;
    bit_en = en; detected = det; clear = clr; rd_if.rd_ready = rdy;
    @(posedge clk);
    ev = det && !m_detp;
    m_detp = det;
    popd = rdy && (m_q.size() > 0);
    op = OP_IDLE;
    if (!clr) begin
      if (ev) op = (m_q.size() < DP || popd) ? (popd ? OP_PUSH_POP : OP_PUSH) : OP_DROP;
      else if (popd) op = OP_POP;
    end
    if (clr) begin
      m_q.delete(); m_bit = 0; m_evt = 0; m_ovf = 1'b0;
    end else begin
      if (op == OP_POP || op == OP_PUSH_POP) junk = m_q.pop_front();
      if (op == OP_PUSH || op == OP_PUSH_POP) m_q.push_back(CW'(m_bit));
      if (op == OP_DROP) m_ovf = 1'b1;
      if (ev && m_evt < 255) m_evt++;
      if (en) m_bit = (m_bit + 1) % 256;
    end
    #1;
  endtask

  task automatic run_to(input int target);
    for (int g = 0; g < 300 && m_bit != target; g++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rstn = 1'b0; bit_en = 0; detected = 0; clear = 0; rd_if.rd_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    n_cmp++; if (rd_if.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", rd_if.rd_valid); end
    n_cmp++; if (rd_if.rd_data !== 8'd0) begin n_err++; $display("FAIL reset_data: got %0d want 0", rd_if.rd_data); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_cmp++; if (event_cnt !== 8'd0 || overflow !== 1'b0 || irq !== 1'b0) begin n_err++;
      $display("FAIL reset_flags: got cnt=%0d ovf=%0b irq=%0b want 0/0/0", event_cnt, overflow, irq); end
  endtask

  task automatic test_basic();
    run_to(4);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (rd_if.rd_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0b want 1", rd_if.rd_valid); end
    n_cmp++; if (rd_if.rd_data !== 8'd4) begin n_err++; $display("FAIL basic_data: got %0d want 4", rd_if.rd_data); end
    n_cmp++; if (event_cnt !== 8'd1) begin n_err++; $display("FAIL basic_cnt: got %0d want 1", event_cnt); end
    n_cmp++; if (fifo_level !== 3'd1 || irq !== 1'b0) begin n_err++;
      $display("FAIL basic_level_irq: got lvl=%0d irq=%0b want 1/0", fifo_level, irq); end
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (fifo_level !== 3'd0 || rd_if.rd_valid !== 1'b0) begin n_err++;
      $display("FAIL basic_pop: got lvl=%0d vld=%0b want 0/0", fifo_level, rd_if.rd_valid); end
  endtask

  task automatic test_held();
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    run_to(7);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL held_level: got %0d want 1", fifo_level); end
    n_cmp++; if (rd_if.rd_data !== 8'd7) begin n_err++; $display("FAIL held_data: got %0d want 7", rd_if.rd_data); end
    n_cmp++; if (event_cnt !== 8'd1) begin n_err++; $display("FAIL held_cnt: got %0d want 1", event_cnt); end
  endtask

  task automatic test_fill_overflow();
    int stamps[5] = '{2, 6, 10, 14, 18};
    int exp[4]    = '{2, 6, 10, 14};
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      run_to(stamps[i]);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (irq !== (i >= 1)) begin n_err++; $display("FAIL fill_irq%0d: got %0b want %0b", i, irq, (i >= 1)); end
    end
    n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL fill_level: got %0d want 4", fifo_level); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL fill_ovf: got %0b want 1", overflow); end
    n_cmp++; if (event_cnt !== 8'd5) begin n_err++; $display("FAIL fill_cnt: got %0d want 5", event_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== CW'(exp[i])) begin n_err++;
        $display("FAIL fill_drain%0d: got vld=%0b data=%0d want 1/%0d", i, rd_if.rd_valid, rd_if.rd_data, exp[i]); end
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
    end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL fill_ovf_sticky: got %0b want 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    int stamps[4] = '{2, 6, 10, 14};
    int exp[4]    = '{6, 10, 14, 20};
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_to(stamps[i]);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
    end
    run_to(20);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pp_ovf: got %0b want 0", overflow); end
    n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL pp_level: got %0d want 4", fifo_level); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== CW'(exp[i])) begin n_err++;
        $display("FAIL pp_drain%0d: got vld=%0b data=%0d want 1/%0d", i, rd_if.rd_valid, rd_if.rd_data, exp[i]); end
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_wrap_saturate();
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 260; k++) cycle(1'b1, (k == 258), 1'b0, 1'b0);
    n_cmp++; if (fifo_level !== 3'd1 || rd_if.rd_data !== 8'd2) begin n_err++;
      $display("FAIL wrap_stamp: got lvl=%0d data=%0d want 1/2", fifo_level, rd_if.rd_data); end
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 300; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      if (k == 253) begin
        n_cmp++; if (event_cnt !== 8'd254) begin n_err++; $display("FAIL sat_254: got %0d want 254", event_cnt); end
      end
    end
    n_cmp++; if (event_cnt !== 8'd255) begin n_err++; $display("FAIL sat_cnt: got %0d want 255", event_cnt); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL sat_ovf: got %0b want 0", overflow); end
  endtask

  task automatic test_clear();
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (2) begin cycle(1'b1, 1'b1, 1'b0, 1'b0); cycle(1'b1, 1'b0, 1'b0, 1'b0); end
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (rd_if.rd_valid !== 1'b0 || fifo_level !== 3'd0 || rd_if.rd_data !== 8'd0) begin n_err++;
      $display("FAIL clr_fifo: got vld=%0b lvl=%0d data=%0d want 0/0/0", rd_if.rd_valid, fifo_level, rd_if.rd_data); end
    n_cmp++; if (event_cnt !== 8'd0 || overflow !== 1'b0 || irq !== 1'b0) begin n_err++;
      $display("FAIL clr_flags: got cnt=%0d ovf=%0b irq=%0b want 0/0/0", event_cnt, overflow, irq); end
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (fifo_level !== 3'd0 || event_cnt !== 8'd0) begin n_err++;
      $display("FAIL clr_detq: got lvl=%0d cnt=%0d want 0/0", fifo_level, event_cnt); end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (rd_if.rd_data !== 8'd2) begin n_err++; $display("FAIL clr_bitcnt: got %0d want 2", rd_if.rd_data); end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin cycle(1'b1, 1'b1, 1'b0, 1'b0); cycle(1'b1, 1'b0, 1'b0, 1'b0); end
    n_cmp++; if (fifo_level !== 3'd3 || irq !== 1'b1) begin n_err++;
      $display("FAIL ar_pre: got lvl=%0d irq=%0b want 3/1", fifo_level, irq); end
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (rd_if.rd_valid !== 1'b0 || fifo_level !== 3'd0 || irq !== 1'b0) begin n_err++;
      $display("FAIL ar_now: got vld=%0b lvl=%0d irq=%0b want 0/0/0", rd_if.rd_valid, fifo_level, irq); end
    n_cmp++; if (event_cnt !== 8'd0 || overflow !== 1'b0) begin n_err++;
      $display("FAIL ar_cnt: got cnt=%0d ovf=%0b want 0/0", event_cnt, overflow); end
    bit_en = 0; detected = 0; rd_if.rd_ready = 0;
    @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      cycle(1'($urandom_range(3) != 0), 1'($urandom_range(99) < 35),
            1'($urandom_range(99) == 0), 1'($urandom_range(99) < 40));
      n_cmp++; if (rd_if.rd_valid !== (m_q.size() > 0)) begin n_err++;
        $display("FAIL rnd_valid c%0d: got %0b want %0b", c, rd_if.rd_valid, (m_q.size() > 0)); end
      n_cmp++; if (fifo_level !== LW'(m_q.size())) begin n_err++;
        $display("FAIL rnd_level c%0d: got %0d want %0d", c, fifo_level, m_q.size()); end
      if (m_q.size() > 0) begin
        n_cmp++; if (rd_if.rd_data !== m_q[0]) begin n_err++;
          $display("FAIL rnd_data c%0d: got %0d want %0d", c, rd_if.rd_data, m_q[0]); end
      end
      n_cmp++; if (event_cnt !== CW'(m_evt)) begin n_err++;
        $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, event_cnt, m_evt); end
      n_cmp++; if (overflow !== m_ovf || irq !== (m_q.size() >= TH)) begin n_err++;
        $display("FAIL rnd_flags c%0d: got ovf=%0b irq=%0b want %0b/%0b", c, overflow, irq, m_ovf, (m_q.size() >= TH)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap_saturate();
    test_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
